// File: rtl/parameters_pkg.sv
// Shared sizing constants and the FSM state type for the data_sync_arb block.
package parameters_pkg;

   localparam int DATA_WIDTH     = 8;   // width of every data bus
   localparam int NUM_REQ        = 4;   // number of requesters (2..8)
   localparam int EN_HIGH_CYCLES = 4;   // cycles bus_enable stays high (>=3)
   localparam int EN_LOW_CYCLES  = 4;   // cycles bus_enable stays low after a transfer (>=3)

   localparam int ID_W    = $clog2(NUM_REQ);
   localparam int CNT_MAX = (EN_HIGH_CYCLES > EN_LOW_CYCLES) ? EN_HIGH_CYCLES : EN_LOW_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      HOLD  = 2'd2,
      GAP   = 2'd3
   } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr, wrapping,
// and returns a one-hot grant for the first active request found.
module rr_arbiter
   import parameters_pkg::*;
#(
   parameter int N  = NUM_REQ,
   parameter int PW = ID_W
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic          valid
);

   logic [PW-1:0] idx;

   // First active request at or after the pointer wins.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      for (int off = 0; off < N; off++) begin
         idx = PW'((int'(ptr) + off) % N);
         if (!valid && req[idx]) begin
            grant[idx] = 1'b1;
            valid      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/data_sync_arb.sv
// Source-domain front end of a CDC data synchronizer: arbitrates among
// requesters, captures the winning word and drives a slow enable level
// (setup, high window, low gap) so the destination 2-FF sync sees it.
module data_sync_arb
   import parameters_pkg::*;
(
   input  logic                          src_clk,
   input  logic                          src_rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            ack,
   output logic [DATA_WIDTH-1:0]         unsync_bus,
   output logic                          bus_enable,
   output logic [ID_W-1:0]               grant_id,
   output logic                          busy
);

   state_e                state, state_n;
   logic [ID_W-1:0]       ptr, ptr_n;
   logic [CNT_W-1:0]      cnt, cnt_n;
   logic [DATA_WIDTH-1:0] bus_n;
   logic                  en_n;
   logic [NUM_REQ-1:0]    ack_n;
   logic [ID_W-1:0]       gid_n;

   logic [NUM_REQ-1:0]    grant;
   logic                  grant_valid;
   logic [ID_W-1:0]       win_id;
   logic [DATA_WIDTH-1:0] win_data;

   rr_arbiter #(.N(NUM_REQ), .PW(ID_W)) u_arb (
      .req   (req),
      .ptr   (ptr),
      .grant (grant),
      .valid (grant_valid)
   );

   // Encode the one-hot grant into an index and select its data slice.
   always_comb begin
      win_id   = '0;
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            win_id   = ID_W'(i);
            win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // State register.
   always_ff @(posedge src_clk or negedge src_rst) begin
      if (!src_rst) state <= IDLE;
      else          state <= state_n;
   end

   // Next-state and next-output logic; requests are only looked at in IDLE.
   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      cnt_n   = cnt;
      bus_n   = unsync_bus;
      en_n    = bus_enable;
      ack_n   = '0;
      gid_n   = grant_id;
      case (state)
         IDLE: begin
            if (grant_valid) begin
               bus_n   = win_data;
               ack_n   = grant;
               gid_n   = win_id;
               ptr_n   = (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + ID_W'(1);
               state_n = SETUP;
            end
         end
         SETUP: begin
            // Data has been stable for a full cycle; now raise the enable.
            en_n    = 1'b1;
            cnt_n   = CNT_W'(EN_HIGH_CYCLES-1);
            state_n = HOLD;
         end
         HOLD: begin
            if (cnt == '0) begin
               en_n    = 1'b0;
               cnt_n   = CNT_W'(EN_LOW_CYCLES-1);
               state_n = GAP;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         GAP: begin
            if (cnt == '0) state_n = IDLE;
            else           cnt_n   = cnt - CNT_W'(1);
         end
         default: state_n = IDLE;
      endcase
   end

   // Datapath registers; reset clears them asynchronously so the enable drops at once.
   always_ff @(posedge src_clk or negedge src_rst) begin
      if (!src_rst) begin
         ptr        <= '0;
         cnt        <= '0;
         unsync_bus <= '0;
         bus_enable <= 1'b0;
         ack        <= '0;
         grant_id   <= '0;
      end else begin
         ptr        <= ptr_n;
         cnt        <= cnt_n;
         unsync_bus <= bus_n;
         bus_enable <= en_n;
         ack        <= ack_n;
         grant_id   <= gid_n;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_data_sync_arb.sv
// Bench for data_sync_arb: directed transfers with a scoreboard of expected
// grants, a monitor for enable/ack/bus behaviour and a slow destination model.
module tb_data_sync_arb;
   import parameters_pkg::*;

   // ---------------- clock / reset ----------------
   logic src_clk = 1'b0;
   logic src_rst = 1'b0;
   logic dst_clk = 1'b0;

   always #5 src_clk = ~src_clk;
   initial begin
      #2;
      forever #15 dst_clk = ~dst_clk;
   end

   logic [NUM_REQ-1:0]            req = '0;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data = '0;
   logic [NUM_REQ-1:0]            ack;
   logic [DATA_WIDTH-1:0]         unsync_bus;
   logic                          bus_enable;
   logic [ID_W-1:0]               grant_id;
   logic                          busy;

   data_sync_arb dut (
      .src_clk    (src_clk),
      .src_rst    (src_rst),
      .req        (req),
      .req_data   (req_data),
      .ack        (ack),
      .unsync_bus (unsync_bus),
      .bus_enable (bus_enable),
      .grant_id   (grant_id),
      .busy       (busy)
   );

   // ---------------- checking ----------------
   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [15:0]           exp_q[$];   // {requester id, data}
   logic [DATA_WIDTH-1:0] cdc_q[$];   // words the destination should see, in order
   bit                    cdc_en = 1'b1;
   int                    ack_cyc[$];
   int                    cyc = 0;

   task automatic push_exp(input int id, input logic [7:0] d);
      exp_q.push_back({8'(id), d});
   endtask

   task automatic set_data(input int id, input logic [7:0] d);
      req_data[id*DATA_WIDTH +: DATA_WIDTH] = d;
   endtask

   always @(posedge src_clk) cyc++;

   // Monitor: ack against scoreboard, bus stability, enable window length.
   logic [15:0]           e;
   logic [NUM_REQ-1:0]    oh;
   logic [DATA_WIDTH-1:0] prev_bus = '0;
   logic                  prev_en  = 1'b0;
   int                    en_len   = 0;

   always @(negedge src_clk) begin
      if (!src_rst) begin
         prev_bus = '0;
         prev_en  = 1'b0;
         en_len   = 0;
      end else begin
         if (ack != '0) begin
            ack_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               check_val("spurious_ack", 32'(ack), 0);
            end else begin
               e = exp_q.pop_front();
               oh = '0;
               oh[e[15:8]] = 1'b1;
               check_val("ack_onehot", 32'(ack), 32'(oh));
               check_val("grant_id", 32'(grant_id), 32'(e[15:8]));
               check_val("capture_data", 32'(unsync_bus), 32'(e[7:0]));
               check_val("en_low_in_setup", 32'(bus_enable), 0);
               if (cdc_en) cdc_q.push_back(e[7:0]);
            end
         end else if (unsync_bus != prev_bus) begin
            check_val("bus_change", 32'(unsync_bus), 32'(prev_bus));
         end
         if (bus_enable) begin
            en_len++;
         end else if (prev_en) begin
            check_val("en_len", en_len, EN_HIGH_CYCLES);
            en_len = 0;
         end
         prev_en  = bus_enable;
         prev_bus = unsync_bus;
      end
   end

   // Destination model: 2-FF sync of the enable, capture on its rising edge.
   logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
   always @(posedge dst_clk) begin
      s1 <= bus_enable;
      s2 <= s1;
      s3 <= s2;
   end

   always @(posedge dst_clk) begin
      if (s2 && !s3 && cdc_en) begin
         if (cdc_q.size() == 0) check_val("cdc_extra", 0, 1);
         else                   check_val("cdc_word", 32'(unsync_bus), 32'(cdc_q.pop_front()));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_ack(output int n);
      n = 0;
      for (int i = 1; i <= 50; i++) begin
         @(negedge src_clk);
         n = i;
         if (ack != '0) break;
      end
      check_val("ack_seen", 32'(ack != '0), 1);
   endtask

   task automatic wait_idle();
      for (int i = 1; i <= 50; i++) begin
         @(negedge src_clk);
         if (!busy) break;
      end
      check_val("idle_seen", 32'(busy), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   int n;
   int base;

   initial begin
      // Reset values
      src_rst = 1'b0;
      repeat (3) @(negedge src_clk);
      check_val("rst_ack", 32'(ack), 0);
      check_val("rst_bus", 32'(unsync_bus), 0);
      check_val("rst_en", 32'(bus_enable), 0);
      check_val("rst_gid", 32'(grant_id), 0);
      check_val("rst_busy", 32'(busy), 0);
      #2 src_rst = 1'b1;

      // Single requester 2 with 0xA5
      @(negedge src_clk);
      set_data(2, 8'hA5);
      req[2] = 1'b1;
      push_exp(2, 8'hA5);
      wait_ack(n);
      check_val("t1_ack_lat", n, 1);
      req = '0;
      @(negedge src_clk);
      check_val("t1_en_rise", 32'(bus_enable), 1);
      wait_idle();

      // All requesters continuously: order 0,1,2,3,0 every 10 cycles
      src_rst = 1'b0;
      @(negedge src_clk);
      #2 src_rst = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) set_data(i, 8'(i * 8'h11));
      @(negedge src_clk);
      req  = '1;
      base = ack_cyc.size();
      for (int k = 0; k < 5; k++) push_exp(k % NUM_REQ, 8'((k % NUM_REQ) * 8'h11));
      for (int k = 0; k < 5; k++) wait_ack(n);
      req = '0;
      wait_idle();
      for (int k = 1; k < 5; k++)
         check_val("t2_spacing", ack_cyc[base+k] - ack_cyc[base+k-1], 2 + EN_HIGH_CYCLES + EN_LOW_CYCLES);

      // Request arriving during HOLD waits for IDLE
      @(negedge src_clk);
      set_data(2, 8'h3C);
      req[2] = 1'b1;
      push_exp(2, 8'h3C);
      base = ack_cyc.size();
      wait_ack(n);
      req[2] = 1'b0;
      @(negedge src_clk);
      set_data(1, 8'h5A);
      req[1] = 1'b1;
      push_exp(1, 8'h5A);
      wait_ack(n);
      check_val("t3_wait", n, 9);
      req[1] = 1'b0;
      wait_idle();
      check_val("t3_spacing", ack_cyc[base+1] - ack_cyc[base], 2 + EN_HIGH_CYCLES + EN_LOW_CYCLES);

      // Reset in the 2nd HOLD cycle, req[3] still high afterwards
      cdc_en = 1'b0;
      @(negedge src_clk);
      set_data(3, 8'h77);
      req[3] = 1'b1;
      push_exp(3, 8'h77);
      wait_ack(n);
      @(negedge src_clk);
      @(negedge src_clk);
      #2 src_rst = 1'b0;
      #1;
      check_val("t4_rst_en", 32'(bus_enable), 0);
      check_val("t4_rst_ack", 32'(ack), 0);
      check_val("t4_rst_bus", 32'(unsync_bus), 0);
      check_val("t4_rst_gid", 32'(grant_id), 0);
      check_val("t4_rst_busy", 32'(busy), 0);
      set_data(3, 8'h88);
      @(negedge src_clk);
      @(negedge src_clk);
      #2 src_rst = 1'b1;
      push_exp(3, 8'h88);
      wait_ack(n);
      check_val("t4_ack_lat", n, 1);
      req = '0;
      wait_idle();
      repeat (10) @(negedge src_clk);
      cdc_en = 1'b1;

      // One-cycle req[0] pulse while busy is lost
      @(negedge src_clk);
      set_data(2, 8'h12);
      req[2] = 1'b1;
      push_exp(2, 8'h12);
      base = ack_cyc.size();
      wait_ack(n);
      req[2] = 1'b0;
      @(negedge src_clk);
      @(negedge src_clk);
      req[0] = 1'b1;
      @(negedge src_clk);
      req[0] = 1'b0;
      wait_idle();
      repeat (15) @(negedge src_clk);
      check_val("t5_ack_count", ack_cyc.size() - base, 1);
      check_val("t5_busy", 32'(busy), 0);
      check_val("t5_exp_empty", exp_q.size(), 0);

      // Destination must have drained every word
      repeat (20) @(negedge src_clk);
      check_val("cdc_drain", cdc_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
